// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU (EX stage), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: finish at launch when divisor is 0 or |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             qbit;
  logic [WIDTH-1:0] prem_next, q_next;

  assign dvd_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;

  // The stored partial remainder is always < divisor, so its (WIDTH+1)th bit is
  // implicitly zero; only the shifted trial value needs the extra bit.
  assign shifted   = {prem_q, dvd_q[WIDTH-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  assign qbit      = ~trial[WIDTH];
  assign prem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_next    = {dvd_q[WIDTH-2:0], qbit};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          dvd_d   = dvd_mag;
          dvs_d   = dvs_mag;
          negq_d  = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d  = sign & dividend[WIDTH-1];
          prem_d  = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef DIV_EARLY_OUT_EN
          if (divisor == '0) begin
            quo_d   = (sign && dividend[WIDTH-1]) ? WIDTH'(1) : '1;
            rem_d   = dividend;
            state_d = DONE;
          end else if (dvd_mag < dvs_mag) begin
            quo_d   = '0;
            rem_d   = dividend;
            state_d = DONE;
          end
`endif
        end
      end

      CALC: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          prem_d = prem_next;
          dvd_d  = q_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            // Results are taken from this cycle's iteration so they land on DONE entry.
            quo_d   = negq_q ? -q_next : q_next;
            rem_d   = negr_q ? -prem_next : prem_next;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes model results, negedge monitor checks each done pulse.
module tb_div_unit;
  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic         clk, rst, start, sign, flush;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done;

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign), .flush(flush),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           edge_no;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           edge_cnt = 0;
  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // MIPS DIV/DIVU semantics with plain integer arithmetic (truncating division).
  function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output bit early);
    longint sa, sbv, qq, rr, ma, mb;
    sa  = s ? longint'($signed(a)) : longint'(a);
    sbv = s ? longint'($signed(b)) : longint'(b);
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sbv < 0) ? -sbv : sbv;
    if (b == '0) begin
      q = (s && a[W-1]) ? W'(1) : '1;
      r = a;
    end else begin
      qq = sa / sbv;
      rr = sa % sbv;
      q  = qq[W-1:0];
      r  = rr[W-1:0];
    end
    early = (b == '0) || (ma < mb);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drives start for one edge; afterwards the caller is in cycle 1 (edge + #1).
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_done);
    exp_t         e;
    logic [W-1:0] q, r;
    bit           early;
    model(s, a, b, q, r, early);
    sign = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (expect_done) begin
      e.q = q;
      e.r = r;
      e.edge_no = edge_cnt + ((EARLY_EN && early) ? 0 : W);
      sb.push_back(e);
      held_q = q;
      held_r = r;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles expected busy=0", n);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at edge %0d expected no pulse", edge_cnt);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        total++;
        if (edge_cnt != e.edge_no) begin
          bad++;
          $display("FAIL done_latency: got edge %0d expected %0d", edge_cnt, e.edge_no);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

  logic         t_s[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] t_a[6]  = '{32'hFFFFFFF9, 32'h7, 32'h80000000, 32'h12345678, 32'h80000005, 32'h5};
  logic [W-1:0] t_b[6]  = '{32'h2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};

  initial begin
    logic [W-1:0] a, b;
    rst = 1'b0; start = 1'b0; sign = 1'b0; flush = 1'b0;
    dividend = '0; divisor = '0;
    #2;
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_done", done, 1'b0);
    chk("reset_quotient", quotient, '0);
    chk("reset_remainder", remainder, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // DIVU 100/7 with busy window and ignored start pulses in cycles 5 and 33
    launch(1'b0, 32'd100, 32'd7, 1'b1);
    for (int n = 1; n <= W + 2; n++) begin
      chk_bit("busy_window", busy, n <= W + 1);
      if (n == 5 || n == W + 1) begin
        start = 1'b1; dividend = $urandom; divisor = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end

    for (int i = 0; i < 6; i++) begin
      launch(t_s[i], t_a[i], t_b[i], 1'b1);
      wait_idle();
    end

    // flush in cycle 10, relaunch in cycle 11
    launch(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk_bit("flush_busy", busy, 1'b0);
    chk("flush_hold_q", quotient, held_q);
    chk("flush_hold_r", remainder, held_r);
    launch(1'b0, 32'd1000, 32'd3, 1'b1);
    wait_idle();

    // start and flush together in IDLE
    sign = 1'b0; dividend = 32'd50; divisor = 32'd5;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk_bit("start_flush_busy", busy, 1'b0);
    repeat (3) begin @(posedge clk); #1; end

    // asynchronous reset in cycle 15
    launch(1'b0, 32'hDEADBEEF, 32'h1234, 1'b0);
    repeat (14) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    chk_bit("async_busy", busy, 1'b0);
    chk_bit("async_done", done, 1'b0);
    chk("async_quotient", quotient, '0);
    chk("async_remainder", remainder, '0);
    held_q = '0; held_r = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    launch(1'b1, -32'sd100, 32'd9, 1'b1);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        1: b = '0;
        2: b = W'($urandom_range(1, 15));
        3: begin a = 32'h80000000; b = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : b; end
        4: a = W'($urandom_range(0, 255));
        default: ;
      endcase
      launch(1'($urandom_range(0, 1)), a, b, 1'b1);
      wait_idle();
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
